// File: rtl/operand_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_capture_pkg
// Description : Shared types and constants for the operand capture front end.
//               Holds the capture FSM state encoding and the one-hot state
//               indicator patterns driven onto LEDR[2:0].
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package operand_capture_pkg;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_SHOW   = 2'd2
    } state_t;

    localparam logic [2:0] c_LED_LOAD_A = 3'b001;
    localparam logic [2:0] c_LED_LOAD_B = 3'b010;
    localparam logic [2:0] c_LED_SHOW   = 3'b100;

    // Map a state to its one-hot LED pattern; the unused encoding falls back
    // to the LOAD_A pattern so the indicator never shows an illegal code.
    function automatic logic [2:0] state_to_led(input state_t s);
        logic [2:0] led;
        led = c_LED_LOAD_A;
        case (s)
            ST_LOAD_A: led = c_LED_LOAD_A;
            ST_LOAD_B: led = c_LED_LOAD_B;
            ST_SHOW:   led = c_LED_SHOW;
            default:   led = c_LED_LOAD_A;
        endcase
        return led;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, stable-level debouncer and press-event
//               generator for an active-low pushbutton.
// Ports       : clk_i    - clock, rising edge
//               RESET_N  - synchronous active-low reset
//               key_n_i  - raw asynchronous bouncy button, active-low
//               press_o  - one-cycle registered pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic RESET_N,
    input  logic key_n_i,
    output logic press_o
);

    localparam int              CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   c_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_prev_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The debounced level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, so the counter itself never exceeds DEBOUNCE_CYCLES-1.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == c_CNT_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end
    end

    // Edge detect against the previous debounced level: the pulse lands one
    // cycle after the debounced fall. Releases produce no event.
    always_comb begin
        press_d = deb_prev_q & ~deb_q;
    end

    always_ff @(posedge clk_i) begin
        if (!RESET_N) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= key_n_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/operand_capture.sv
`default_nettype none
// ============================================================================
// Module      : operand_capture
// Description : Steps through capture of two 4-bit operands from the slide
//               switches on debounced pushbutton presses, presenting them with
//               a valid flag to the comparator / seven-segment stage.
// Ports       : MAX10_CLK1_50 - clock, rising edge
//               RESET_N       - synchronous active-low reset
//               SW[3:0]       - operand data switches
//               KEY_N         - raw pushbutton, active-low
//               OP_A[3:0]     - captured operand A (upper nibble)
//               OP_B[3:0]     - captured operand B (lower nibble)
//               OP_VALID      - both operands held for display
//               STATE_LED[2:0]- one-hot state: 001 LOAD_A, 010 LOAD_B, 100 SHOW
// Revision    : 1.0 - initial release
// ============================================================================
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET_N,
    input  logic [3:0] SW,
    input  logic       KEY_N,
    output logic [3:0] OP_A,
    output logic [3:0] OP_B,
    output logic       OP_VALID,
    output logic [2:0] STATE_LED
);

    logic       press_w;

    state_t     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       valid_q, valid_d;
    logic [2:0] led_q, led_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i   (MAX10_CLK1_50),
        .RESET_N (RESET_N),
        .key_n_i (KEY_N),
        .press_o (press_w)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        valid_d = valid_q;
        if (press_w) begin
            case (state_q)
                ST_LOAD_A: begin
                    op_a_d  = SW;
                    state_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    op_b_d  = SW;
                    valid_d = 1'b1;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD_A;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD_A;
                end
            endcase
        end
        // Indicator is registered from the next state so it changes on the
        // same edge as the state itself.
        led_d = state_to_led(state_d);
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            state_q <= ST_LOAD_A;
            op_a_q  <= 4'h0;
            op_b_q  <= 4'h0;
            valid_q <= 1'b0;
            led_q   <= c_LED_LOAD_A;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= valid_d;
            led_q   <= led_d;
        end
    end

    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign OP_VALID  = valid_q;
    assign STATE_LED = led_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_capture
// Description : Directed self-checking bench for operand_capture with a short
//               debounce window of 4 cycles.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_capture;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       key_n;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_valid;
    logic [2:0] state_led;

    int checks   = 0;
    int failures = 0;

    operand_capture #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET_N       (rst_n),
        .SW            (sw),
        .KEY_N         (key_n),
        .OP_A          (op_a),
        .OP_B          (op_b),
        .OP_VALID      (op_valid),
        .STATE_LED     (state_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic v, input logic [2:0] led);
        chk({tag, ".op_a"},  {4'h0, op_a},      {4'h0, a});
        chk({tag, ".op_b"},  {4'h0, op_b},      {4'h0, b});
        chk({tag, ".valid"}, {7'h0, op_valid},  {7'h0, v});
        chk({tag, ".led"},   {5'h0, state_led}, {5'h0, led});
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        sw    = 4'h0;
        tick(3);
        chk_all("reset", 4'h0, 4'h0, 1'b0, 3'b001);
        rst_n = 1'b1;
        tick(20);
        chk_all("idle", 4'h0, 4'h0, 1'b0, 3'b001);

        // Clean press into LOAD_A: capture lands on the 8th edge after the fall.
        sw    = 4'h1;
        key_n = 1'b0;
        tick(7);
        chk_all("pressA_e7", 4'h0, 4'h0, 1'b0, 3'b001);
        tick(1);
        chk_all("pressA_e8", 4'h1, 4'h0, 1'b0, 3'b010);
        tick(12);
        chk_all("pressA_held", 4'h1, 4'h0, 1'b0, 3'b010);
        key_n = 1'b1;
        tick(10);

        // Press into LOAD_B.
        sw    = 4'hA;
        key_n = 1'b0;
        tick(7);
        chk_all("pressB_e7", 4'h1, 4'h0, 1'b0, 3'b010);
        tick(1);
        chk_all("pressB_e8", 4'h1, 4'hA, 1'b1, 3'b100);
        key_n = 1'b1;
        tick(10);

        // Press in SHOW clears valid, keeps operands.
        key_n = 1'b0;
        tick(8);
        chk_all("pressShow", 4'h1, 4'hA, 1'b0, 3'b001);
        key_n = 1'b1;
        tick(10);

        // Switch changes without a press do nothing.
        sw = 4'hF;
        tick(5);
        chk_all("swOnly", 4'h1, 4'hA, 1'b0, 3'b001);

        // Bouncy press: short lows never qualify; one capture after final fall.
        sw = 4'h6;
        for (int k = 0; k < 3; k++) begin
            key_n = 1'b0;
            tick(2);
            key_n = 1'b1;
            tick(1);
        end
        key_n = 1'b0;
        tick(7);
        chk_all("bounce_e7", 4'h1, 4'hA, 1'b0, 3'b001);
        tick(1);
        chk_all("bounce_e8", 4'h6, 4'hA, 1'b0, 3'b010);
        tick(10);
        chk_all("bounce_held", 4'h6, 4'hA, 1'b0, 3'b010);
        key_n = 1'b1;
        tick(10);

        // Reset mid-debounce in LOAD_B (counter at 3 after edge 5).
        sw    = 4'h9;
        key_n = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk_all("midReset", 4'h0, 4'h0, 1'b0, 3'b001);
        rst_n = 1'b1;

        // Key still held through reset release: fresh capture into OP_A.
        tick(7);
        chk_all("heldRst_e7", 4'h0, 4'h0, 1'b0, 3'b001);
        tick(1);
        chk_all("heldRst_e8", 4'h9, 4'h0, 1'b0, 3'b010);
        tick(20);
        chk_all("heldRst_hold", 4'h9, 4'h0, 1'b0, 3'b010);
        key_n = 1'b1;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_capture.md
# operand_capture

Front-end stage of the Unit2 magnitude-comparator path on the DE10-Lite. A single pushbutton steps through capture of two 4-bit operands taken from the slide switches. The block presents the operands with a valid flag to the comparator/seven-segment stage, which consumes them in place of the raw SW[7:4]/SW[3:0] fields. It synchronises and debounces the raw button and sequences the loads with a three-state FSM.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); legal range ≥ 2.
- MAX10_CLK1_50  in  1  sole clock, all logic on rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- SW  in  4  operand data switches (quasi-static, sampled on capture edge).
- KEY_N  in  1  raw pushbutton, active-low, asynchronous, bouncy.
- OP_A  out  4  captured operand A (comparator upper nibble).
- OP_B  out  4  captured operand B (comparator lower nibble).
- OP_VALID  out  1  high while both operands are held for display.
- STATE_LED  out  3  one-hot state indicator to LEDR[2:0]: 001 LOAD_A, 010 LOAD_B, 100 SHOW.

## Operation
- Synchroniser: 2-FF on KEY_N, reset value 1 (released).
- Debounce: counter clears whenever synchronised level equals debounced level; otherwise it increments. Debounced level takes the synchronised value on the edge where the counter would reach DEBOUNCE_CYCLES. Counter then clears. Any bounce back to the debounced level before that restarts the count.
- Press event: one-cycle pulse, registered, high in the cycle after the debounced level falls 1→0. A release (0→1) is debounced identically but produces no event.
- FSM on press pulse:
  - LOAD_A: OP_A ← SW; go LOAD_B.
  - LOAD_B: OP_B ← SW, OP_VALID ← 1; go SHOW.
  - SHOW: OP_VALID ← 0; go LOAD_A. OP_A/OP_B retain their values.
- No press: state and outputs hold. SW changes never affect OP_A/OP_B outside a capture edge.
- Reset values, applied on any edge with RESET_N=0, including mid-debounce or mid-sequence:
  - state LOAD_A, OP_A=0, OP_B=0, OP_VALID=0, STATE_LED=001;
  - sync regs=1, debounced=1, counter=0, press pulse=0.
  - In-progress debounce is discarded.
- Button held low through reset release: seen as a fresh press after full sync + debounce latency. This is intended.
- Counter width $clog2(DEBOUNCE_CYCLES+1). Counting saturates by construction and never wraps.

## Timing
- Raw KEY_N falls and stays low before edge 0:
  - synchronised low after edge 2;
  - debounced low after edge 2+DEBOUNCE_CYCLES;
  - press pulse high for cycle following edge 3+DEBOUNCE_CYCLES... correction: press pulse registered at edge 3+DEBOUNCE_CYCLES;
  - FSM capture and outputs update at edge 4+DEBOUNCE_CYCLES.
- Capture uses SW value present at that edge.
- OP_VALID and STATE_LED change on the same edge as the capture/state change. All outputs are registered.
- At most one state advance per debounced press, regardless of hold duration.
- Minimum press spacing is 2×DEBOUNCE_CYCLES+O(1) cycles (press + release debounce).

## Structure
- Shared package operand_capture_pkg: state enum (LOAD_A, LOAD_B, SHOW) and the one-hot STATE_LED encodings.
- Sub-module key_debounce: synchroniser, debounce counter and press-pulse generator; parameter DEBOUNCE_CYCLES; ports clock, RESET_N, raw key in, press pulse out.
- FSM and operand registers live in operand_capture.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset then idle 20 cycles → OP_A=0, OP_B=0, OP_VALID=0, STATE_LED=001.
- SW=0001, clean press held 20 cycles → OP_A=0001 at edge 8 after KEY_N fall, STATE_LED=010. SW=1010, release + press → OP_B=1010, OP_VALID=1, STATE_LED=100.
- Bounce KEY_N low 2 cycles / high 1 cycle ×3, then low steady → exactly one capture, 8 edges after the final fall. Pulses shorter than 4 stable cycles cause no capture.
- In SHOW, press → OP_VALID=0, STATE_LED=001, OP_A/OP_B unchanged. Change SW without pressing → outputs unchanged.
- Assert RESET_N=0 for 1 cycle at counter=3 mid-debounce in LOAD_B → next edge all outputs at reset values and no capture occurs.
- Hold KEY_N low through reset release → single capture into OP_A at edge 8 after release, no further advance while held.
